// File: rtl/lfsr_scan_ctrl.sv
// lfsr_scan_ctrl: steps a shared PRBS/LFSR checker across the enabled lanes
// behind an N:1 mux. For each lane it selects the lane, lets the checker
// train, snapshots the checker's free-running counters, waits out the
// measurement window and reports end-minus-base deltas as one result record.
//
// Handshake: start_i is a single-cycle request, accepted only when the
// controller is idle and abort_i is low. done_o is a single-cycle pulse
// marking the end of a scan, whether it completed or was aborted.
// res_valid_o is a single-cycle strobe that qualifies res_* in that cycle.
// There is no backpressure on either result or done.
module lfsr_scan_ctrl #(
  parameter int LANES         = 4,
  parameter int LANE_BITS     = 2,
  parameter int STAT_WIDTH    = 32,
  parameter int WIN_WIDTH     = 24,
  parameter int SETTLE_CYCLES = 64,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [LANES-1:0]      lane_mask_i,
  input  logic [WIN_WIDTH-1:0]  window_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic [LANES-1:0]      pass_mask_o,
  output logic                  res_valid_o,
  output logic [LANE_BITS-1:0]  res_lane_o,
  output logic                  res_pass_o,
  output logic [STAT_WIDTH-1:0] res_ber_o,
  output logic [STAT_WIDTH-1:0] res_sync_o,
  output logic [STAT_WIDTH-1:0] res_lost_o,
  output logic                  chk_en_o,
  output logic [LANE_BITS-1:0]  chk_lane_o,
  input  logic [STAT_WIDTH-1:0] chk_ber_i,
  input  logic [STAT_WIDTH-1:0] chk_sync_i,
  input  logic [STAT_WIDTH-1:0] chk_lost_i,
  output logic [2:0]            dbg_state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GAP    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SNAP   = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;

  // One down-counter serves GAP, SETTLE and RUN; wide enough for all three.
  localparam int CNT_W = (WIN_WIDTH > 16) ? WIN_WIDTH : 16;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LANES-1:0]      mask_q;
  logic [WIN_WIDTH-1:0]  win_q;
  logic [LANE_BITS-1:0]  lane_ptr_q;
  logic [STAT_WIDTH-1:0] base_ber_q, base_sync_q, base_lost_q;

  logic [LANE_BITS:0]    first_hit;   // {found, lane} over the incoming mask
  logic [LANE_BITS:0]    next_hit;    // {found, lane} above the current lane
  logic [LANE_BITS:0]    next_from;
  logic [STAT_WIDTH-1:0] ber_delta, sync_delta, lost_delta;
  logic                  delta_pass;
  logic                  abort_act;

  // Lowest set mask bit at or above 'from'; MSB of the result flags a hit.
  function automatic logic [LANE_BITS:0] find_lane(input logic [LANES-1:0] m,
                                                   input logic [LANE_BITS:0] from);
    logic [LANE_BITS:0] r;
    r = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (((LANE_BITS+1)'(i) >= from) && m[i]) begin
        r = {1'b1, LANE_BITS'(i)};
      end
    end
    return r;
  endfunction

  // Checker is enabled from SETTLE through REPORT, so it never sees a mux switch.
  function automatic logic en_state(input logic [2:0] s);
    return (s == S_SETTLE) || (s == S_SNAP) || (s == S_RUN) || (s == S_REPORT);
  endfunction

  assign dbg_state_o = state_q;
  assign abort_act   = abort_i && (state_q != S_IDLE);
  assign next_from   = {1'b0, lane_ptr_q} + {{LANE_BITS{1'b0}}, 1'b1};
  assign first_hit   = find_lane(lane_mask_i, '0);
  assign next_hit    = find_lane(mask_q, next_from);

  // Modular subtraction gives the right delta even when a counter wraps.
  assign ber_delta   = chk_ber_i  - base_ber_q;
  assign sync_delta  = chk_sync_i - base_sync_q;
  assign lost_delta  = chk_lost_i - base_lost_q;
  assign delta_pass  = ((ber_delta | sync_delta | lost_delta) == '0);

  // Next-state and phase counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i && (lane_mask_i != '0)) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SNAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SNAP: begin
        state_d = S_RUN;
        cnt_d   = CNT_W'(win_q) - CNT_W'(1);
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_REPORT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_REPORT: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (next_hit[LANE_BITS]) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_act) begin
      state_d = S_IDLE;
    end
  end

  // State, registered outputs, snapshots and result records.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      win_q       <= '0;
      lane_ptr_q  <= '0;
      base_ber_q  <= '0;
      base_sync_q <= '0;
      base_lost_q <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      aborted_o   <= 1'b0;
      pass_mask_o <= '0;
      res_valid_o <= 1'b0;
      res_lane_o  <= '0;
      res_pass_o  <= 1'b0;
      res_ber_o   <= '0;
      res_sync_o  <= '0;
      res_lost_o  <= '0;
      chk_en_o    <= 1'b0;
      chk_lane_o  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_o      <= (state_d != S_IDLE);
      chk_en_o    <= en_state(state_d);
      done_o      <= 1'b0;
      res_valid_o <= 1'b0;
      if (abort_act) begin
        done_o    <= 1'b1;
        aborted_o <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              mask_q      <= lane_mask_i;
              win_q       <= (window_i == '0) ? WIN_WIDTH'(1) : window_i;
              pass_mask_o <= '0;
              aborted_o   <= 1'b0;
              if (lane_mask_i == '0) begin
                done_o <= 1'b1;
              end else begin
                lane_ptr_q <= first_hit[LANE_BITS-1:0];
                chk_lane_o <= first_hit[LANE_BITS-1:0];
              end
            end
          end
          S_SNAP: begin
            base_ber_q  <= chk_ber_i;
            base_sync_q <= chk_sync_i;
            base_lost_q <= chk_lost_i;
          end
          S_REPORT: begin
            res_valid_o             <= 1'b1;
            res_lane_o              <= lane_ptr_q;
            res_pass_o              <= delta_pass;
            res_ber_o               <= ber_delta;
            res_sync_o              <= sync_delta;
            res_lost_o              <= lost_delta;
            pass_mask_o[lane_ptr_q] <= delta_pass;
          end
          S_NEXT: begin
            if (next_hit[LANE_BITS]) begin
              lane_ptr_q <= next_hit[LANE_BITS-1:0];
              chk_lane_o <= next_hit[LANE_BITS-1:0];
            end else begin
              done_o <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/lfsr_scan_ctrl.md
# lfsr_scan_ctrl

Sequencer for a shared PRBS/LFSR checker behind an N:1 lane mux. On a host start it walks every enabled lane in ascending order: it selects the lane, re-arms the checker, waits out LFSR training, and measures a fixed error window by snapshot-differencing the checker's free-running statistics counters. It then emits a per-lane result record. It sits between the register/host interface and the lane mux plus checker in the ADC/DAC link-test path.

## Interface
- LANES, 4: number of lanes behind the mux (1..16)
- LANE_BITS, 2: width of the lane select (>= clog2(LANES), min 1)
- STAT_WIDTH, 32: width of the checker statistics counters
- WIN_WIDTH, 24: width of the measurement-window length
- SETTLE_CYCLES, 64: enabled cycles before the base snapshot; must exceed checker training plus counter latency
- GAP_CYCLES, 2: checker-disabled cycles between lanes (min 1)

Ports:
- clk  in  1  single clock domain
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  one-cycle start request; honoured only in IDLE
- abort_i  in  1  stop the scan; takes priority over everything except rst
- lane_mask_i  in  LANES  lanes to test; sampled at accepted start
- window_i  in  WIN_WIDTH  RUN length in cycles; sampled at accepted start; 0 is treated as 1
- busy_o  out  1  scan in progress
- done_o  out  1  one-cycle pulse at end of scan or abort
- aborted_o  out  1  set with done_o if the scan was aborted; held until next start
- pass_mask_o  out  LANES  per-lane pass bits; cleared at start
- res_valid_o  out  1  one-cycle result strobe
- res_lane_o  out  LANE_BITS  lane of the result
- res_pass_o  out  1  all three deltas zero
- res_ber_o / res_sync_o / res_lost_o  out  STAT_WIDTH each  window deltas
- chk_en_o  out  1  checker enable
- chk_lane_o  out  LANE_BITS  mux select
- chk_ber_i / chk_sync_i / chk_lost_i  in  STAT_WIDTH each  checker counters; cleared by the checker on its first enabled cycle

## Operation
- States: IDLE, GAP, SETTLE, SNAP, RUN, REPORT, NEXT.
- IDLE + start_i: latch mask and window, clear pass_mask_o and aborted_o, set busy_o.
  - Mask zero: go directly to done, with done_o in the cycle after start.
  - Otherwise: set lane pointer to the lowest set mask bit and enter GAP.
- GAP: chk_en_o=0 for GAP_CYCLES. chk_lane_o is loaded with the lane pointer on GAP entry and changes only here, never while chk_en_o=1.
- SETTLE: chk_en_o=1 for SETTLE_CYCLES. Errors during this state are discarded.
- SNAP: one cycle; register base_{ber,sync,lost} from the checker inputs.
- RUN: window cycles, chk_en_o=1.
- REPORT: one cycle.
  - Deltas are end minus base, modulo 2^STAT_WIDTH; counter wrap gives the correct delta.
  - Register the record and pass bit; set pass_mask_o[lane]=res_pass.
- NEXT: find the next higher set mask bit.
  - Found: go to GAP.
  - None: drop busy_o, pulse done_o, drop chk_en_o, return to IDLE.
- chk_en_o=1 only in SETTLE, SNAP, RUN and REPORT.
- Abort (any non-IDLE state):
  - Next cycle: IDLE, chk_en_o=0, busy_o=0, done_o=1, aborted_o=1.
  - No res_valid_o for the interrupted lane.
  - pass_mask_o keeps the bits of lanes already completed.
- start_i and abort_i in the same IDLE cycle: abort wins; start is ignored and nothing is pulsed.
- start_i while busy is ignored.
- abort_i in IDLE is ignored.

## Timing
- Reset values:
  - IDLE; chk_en_o, busy_o, done_o, aborted_o, res_valid_o, res_pass_o = 0.
  - pass_mask_o, res_* data, chk_lane_o = 0.
- start_i accepted at cycle T: busy_o=1 and the GAP state register are active at T+1; chk_lane_o is valid from T+1.
- Per lane: GAP_CYCLES + SETTLE_CYCLES + 1 + W + 1 cycles, plus 1 NEXT cycle.
- res_valid_o is asserted the cycle after REPORT, concurrent with NEXT.
- After the last lane, done_o is asserted the cycle after NEXT.
- All outputs are registered.
- rst mid-scan returns to the reset values in the following cycle.

## Test plan
- LANES=4, mask=4'b1111, window=100, clean PRBS on all lanes -> 4 results on lanes 0,1,2,3, all deltas 0; pass_mask_o=4'hF; done_o exactly 4*(2+64+1+100+1+1)+1 cycles after start.
- mask=4'b0101, lane 2 injects 3 single-bit errors during RUN -> results only for lanes 0 and 2; lane 2 res_ber_o=3, res_pass_o=0; pass_mask_o=4'b0001.
- Errors injected only during SETTLE on lane 1 -> lane 1 deltas 0, pass=1.
- Checker ber counter preset near 2^32-2 at SNAP, 5 errors in RUN -> res_ber_o=5 (wrap handled).
- abort_i asserted mid-RUN of lane 1 (mask=4'hF) -> next cycle chk_en_o=0, done_o=1, aborted_o=1, pass_mask_o=4'b0001, no lane-1 result.
- mask=0 -> done_o at T+1, aborted_o=0, no res_valid_o. window_i=0 -> RUN lasts exactly 1 cycle.
